// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge-captured, maskable, fixed-priority requests
// presented to the processor over a four-phase ExtIRQ/ExtIAck handshake.
module ext_irq_ctrl #(
  parameter int N_SRC   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64,
  parameter int HOLDOFF = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             clr_err,
  input  logic             ExtIAck,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic             timeout_err,
  output logic             busy
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  // HOLDOFF is expected to be at least 1; the IDLE decision cycle adds one more low cycle.
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE,
    S_HOLDOFF
  } state_t;

  state_t            state_q;
  logic              irq_q;
  logic [ID_W-1:0]   id_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [HO_W-1:0]   ho_cnt_q;

  logic [N_SRC-1:0]  src_prev_q;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic              err_q, err_d;

  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  ack_clr_vec;
  logic [ID_W-1:0]   winner;
  logic              ack_hit;
  logic              tmo_hit;

  always_comb begin
    rise     = src_req & ~src_prev_q;
    eligible = pending_q & mask_q;

    // Scan downwards so the lowest eligible index is the last one written.
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end

    // An ack arriving on the final timeout cycle is still an ack.
    ack_hit = (state_q == S_ASSERT) && ExtIAck;
    tmo_hit = (state_q == S_ASSERT) && !ExtIAck && (to_cnt_q == TO_LAST);

    ack_clr_vec = '0;
    if (ack_hit) ack_clr_vec[id_q] = 1'b1;

    // A fresh edge on the source being acknowledged re-arms it (set wins).
    pending_d = (pending_q & ~ack_clr_vec) | rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
    err_d     = (err_q & ~clr_err) | tmo_hit;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      src_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      err_q      <= 1'b0;
    end else begin
      src_prev_q <= src_req;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      irq_q    <= 1'b0;
      id_q     <= '0;
      to_cnt_q <= '0;
      ho_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          irq_q <= 1'b0;
          // A lingering ack from the previous handshake blocks a new request.
          if ((eligible != '0) && !ExtIAck) begin
            state_q  <= S_ASSERT;
            irq_q    <= 1'b1;
            id_q     <= winner;
            to_cnt_q <= '0;
          end
        end
        S_ASSERT: begin
          if (ack_hit) begin
            state_q <= S_RELEASE;
            irq_q   <= 1'b0;
          end else if (tmo_hit) begin
            state_q  <= S_HOLDOFF;
            irq_q    <= 1'b0;
            ho_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          irq_q <= 1'b0;
          if (!ExtIAck) begin
            state_q  <= S_HOLDOFF;
            ho_cnt_q <= '0;
          end
        end
        S_HOLDOFF: begin
          irq_q <= 1'b0;
          if (ho_cnt_q == HO_LAST) begin
            state_q <= S_IDLE;
          end else begin
            ho_cnt_q <= ho_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ExtIRQ      = irq_q;
  assign irq_id      = id_q;
  assign pending     = pending_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- External interrupt controller: the initiator side of the processor's ExtIRQ/ExtIAck interrupt handshake.
- Collects rising-edge requests from N_SRC peripheral lines into a pending register and applies a per-source enable mask.
- Picks one request by fixed priority, drives ExtIRQ to the processor and holds it until ExtIAck, with a four-phase return-to-zero handshake.
- Sits between the peripheral request lines and the processor_arm ExtIRQ/ExtIAck ports.

Parameters:
- N_SRC, 4, number of interrupt source lines.
- ID_W, 2, width of irq_id; must equal $clog2(N_SRC).
- TIMEOUT, 64, ASSERT-state cycles without ack before abort.
- HOLDOFF, 2, forced ExtIRQ-low cycles between requests.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_req  in  N_SRC  peripheral requests; synchronous to CLOCK_50; rising edge = request.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled.
- clr_err  in  1  one-cycle pulse, clears timeout_err.
- ExtIAck  in  1  acknowledge from processor.
- ExtIRQ  out  1  interrupt request to processor; registered.
- irq_id  out  ID_W  index of the asserted or last-asserted source; registered.
- pending  out  N_SRC  pending register.
- timeout_err  out  1  sticky timeout flag.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (reset=0, async): ExtIRQ=0, irq_id=0, pending=0, timeout_err=0, mask=all ones, edge-detect history=0, state=IDLE, counters=0. ExtIRQ must drop without waiting for a clock edge.
- Edge detect: src_prev is registered each cycle. pending[i] sets at posedge k when src_req[i]=1 and src_prev[i]=0. A line already high at reset release counts as an edge on the first clock.
- Same-cycle set and clear of the same pending bit: set wins.
- Eligible = pending & mask. Winner = lowest set index of eligible.
- A masked pending bit stays pending and is served once it is unmasked.
- mask_we updates mask at the clock edge; the new value is used from the next cycle.
- FSM transitions:
  - IDLE: if eligible != 0 and ExtIAck == 0 -> ASSERT. At that edge ExtIRQ <= 1, irq_id <= winner, timeout counter <= 0.
  - IDLE latency: pending visible in cycle k+1 -> ExtIRQ high in cycle k+2.
  - ASSERT, ExtIAck == 1 sampled: pending[irq_id] <= 0, ExtIRQ <= 0 -> RELEASE.
  - ASSERT, no ack and counter == TIMEOUT-1: ExtIRQ <= 0, timeout_err <= 1, pending unchanged -> HOLDOFF. Otherwise counter increments.
  - ASSERT, general: irq_id is frozen. Mask changes or new edges never withdraw or change the active request.
  - RELEASE: wait until ExtIAck == 0, then -> HOLDOFF. No timeout in this state.
  - HOLDOFF: ExtIRQ=0 for exactly HOLDOFF cycles, then -> IDLE.
- Minimum low time of ExtIRQ between two requests is HOLDOFF+1 cycles (IDLE decision cycle included).
- ExtIAck high while in IDLE blocks a new assertion.
- ExtIAck high in the same cycle the timeout expires: treated as an ack, not a timeout.
- timeout_err: clr_err clears it. clr_err and a new timeout in the same cycle: set wins.
- irq_id holds its last value while idle.
- busy is combinational from state.

Test Plan:
- Reset: hold reset=0 for 2 cycles with src_req=4'b1111 -> ExtIRQ=0, pending=0, busy=0. Release reset -> pending=4'b1111 after the first edge.
- Single source: edge on src_req[2] at posedge k -> pending=4'b0100 in cycle k+1, ExtIRQ=1 and irq_id=2 in cycle k+2. ExtIAck=1 after 3 cycles -> ExtIRQ=0 and pending=0 the next cycle. ExtIAck dropped -> ExtIRQ stays 0 for ≥3 cycles.
- Priority: simultaneous edges on sources 1 and 3 -> first grant irq_id=1; after ack, release and HOLDOFF=2, second grant irq_id=3. ExtIRQ low gap ≥3 cycles.
- Timeout: edge on source 0, ExtIAck held 0 -> ExtIRQ drops after exactly 64 high cycles, timeout_err=1, pending[0]=1. ExtIRQ re-asserts after HOLDOFF. clr_err pulse -> timeout_err=0.
- Masking: mask=4'b1110, edge on source 0 -> pending[0]=1 and ExtIRQ stays 0 for 20 cycles. Write mask=4'b1111 -> ExtIRQ=1, irq_id=0.
- Reset mid-handshake: in ASSERT, drive reset=0 between clock edges -> ExtIRQ=0 immediately and pending=0. After release with no new edges, ExtIRQ stays 0.
